alu: RTL and testbench
======================

# alu

Execute-stage arithmetic/logic unit of the single-issue RV32I core. It takes a one-hot decoded instruction vector from the decoder, two register operand values, a 12-bit immediate and the PC. It produces a registered result for writeback and drives the data-memory interface for loads and stores. It sits between the decode stage and the register-file writeback path.

## Interface
- No parameters.
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rs1  in  32  operand A value. A narrower driver is zero-extended.
- rs2  in  32  operand B value / store data.
- imm  in  12  immediate, always sign-extended to 32 bits (sext).
- PC  in  32  address of the current instruction.
- dmem_rd_data  in  32  word read from data memory at word address addr[14:2]; combinational read.
- instructions  in  39  one-hot decoded instruction vector (index map below).
- ALUenabled  in  1  execute enable.
- addr  out  15  data-memory byte address.
- rd_en  out  1  data-memory read enable.
- wr_en  out  1  data-memory write enable (full-word write).
- dmem_wr_data  out  32  word to write.
- ALUoutput  out  32  registered result.

## Operation
- Index map:
  - 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU
  - 10 ADDI, 11 XORI, 12 ORI, 13 ANDI, 14 SLLI, 15 SRLI, 16 SRAI, 17 SLTI, 18 SLTIU
  - 19 LB, 20 LH, 21 LW, 22 LBU, 23 LHU, 24 SB, 25 SH, 26 SW
  - 27 BEQ, 28 BNE, 29 BLT, 30 BGE, 31 BLTU, 32 BGEU
  - 33 JAL, 34 JALR, 35 LUI, 36 AUIPC, 37 ECALL, 38 EBREAK
- More than one bit set: the highest set index wins. No bit set: no operation.
- Reg/imm ops: standard RV32I semantics, modulo 2^32. Shift amount is operand B[4:0] or imm[4:0]. SLT-type results are 0 or 1.
- Branches: result is 1 if taken, else 0. Signed compare for BLT/BGE, unsigned for BLTU/BGEU.
- JAL/JALR: result is PC+4 (link value).
- LUI: result is sext(imm)<<12. AUIPC: result is PC + (sext(imm)<<12).
- ECALL/EBREAK: result 0.
- Effective address for loads/stores is (rs1+sext(imm))[14:0], driven on addr.
- Loads: rd_en=1.
  - LB/LBU select byte addr[1:0]; LH/LHU select half addr[1]; LW takes the whole word.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Stores: rd_en=1 and wr_en=1. dmem_wr_data is dmem_rd_data with the selected lane(s) replaced by rs2's low byte, low half or whole word (read-modify-write).
- When not a load/store, or when ALUenabled=0: addr=0, rd_en=0, wr_en=0, dmem_wr_data=0.

## Timing
- addr, rd_en, wr_en and dmem_wr_data are combinational from the current inputs.
- ALUoutput updates on the rising clk edge when ALUenabled=1 and a valid op is selected. Latency is 1 cycle.
- Stores and no-op cycles leave ALUoutput unchanged. ALUenabled=0 also holds it.
- Reset: ALUoutput=0 immediately on rst_n low, independent of clk. Memory outputs follow the combinational rules above.
- Reset asserted mid-operation discards the in-flight result. The first update occurs on the first rising edge after rst_n is released.

## Configuration
- ALU_MISALIGN_EN
  - Defined: LH/LHU/SH with addr[0]=1, and LW/SW with addr[1:0]≠0, are suppressed: rd_en=wr_en=0 and ALUoutput loads 0.
  - Undefined: LW/SW ignore addr[1:0], and halfword accesses ignore addr[0], treating the access as aligned down.

## Structure
- Shared package alu_pkg holds:
  - the 39 instruction index constants (ADD_IDX … EBREAK_IDX)
  - the XLEN=32 and DADDR_W=15 constants
  - a result typedef
- One natural sub-module, alu_lsu_lane, handles load extraction/extension and store lane merge.

## Test plan
- Reset, then rs1=5, rs2=4, imm=12, PC=2, ALUenabled=1, set bits cumulatively with the highest set bit winning:
  - bit0 → 9; bit1 → 1; bit7 → 0; bit18 → 1
  - bit33 → 6; bit35 → 0x0000C000; bit36 → 0x0000C002
- rst_n low mid-run → ALUoutput=0 asynchronously. ALUenabled=0 with bit0 → ALUoutput holds, rd_en=wr_en=0.
- LW: rs1=0x100, imm=4, dmem_rd_data=0xDEADBEEF → addr=0x104, rd_en=1, next edge ALUoutput=0xDEADBEEF.
  - LB at addr 0x103 → 0xFFFFFFDE.
  - LBU at addr 0x103 → 0x000000DE.
- SB: rs1=0x101, imm=0, rs2=0xAB, dmem_rd_data=0x11223344 → wr_en=1, dmem_wr_data=0x1122AB44. SH at 0x102 with rs2=0xBEEF → 0xBEEF3344.
- rs1=0xFFFFFFFF, rs2=1: BLT → 1, BLTU → 0, BNE → 1, BEQ → 0.
- With ALU_MISALIGN_EN: LW at 0x102 → rd_en=0, ALUoutput=0. Without: LW at 0x102 → rd_en=1, returns the aligned word.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and types for the RV32I execute-stage ALU.
//   - XLEN / DADDR_W datapath widths
//   - one-hot instruction vector index constants (ADD_IDX .. EBREAK_IDX)
//   - result_t result word type, ls_size_e access size, sext12 helper
package alu_pkg;
    localparam int XLEN      = 32;
    localparam int DADDR_W   = 15;
    localparam int NUM_INSTR = 39;

    localparam logic [5:0] ADD_IDX   = 6'd0,  SUB_IDX   = 6'd1,  XOR_IDX   = 6'd2;
    localparam logic [5:0] OR_IDX    = 6'd3,  AND_IDX   = 6'd4,  SLL_IDX   = 6'd5;
    localparam logic [5:0] SRL_IDX   = 6'd6,  SRA_IDX   = 6'd7,  SLT_IDX   = 6'd8;
    localparam logic [5:0] SLTU_IDX  = 6'd9,  ADDI_IDX  = 6'd10, XORI_IDX  = 6'd11;
    localparam logic [5:0] ORI_IDX   = 6'd12, ANDI_IDX  = 6'd13, SLLI_IDX  = 6'd14;
    localparam logic [5:0] SRLI_IDX  = 6'd15, SRAI_IDX  = 6'd16, SLTI_IDX  = 6'd17;
    localparam logic [5:0] SLTIU_IDX = 6'd18, LB_IDX    = 6'd19, LH_IDX    = 6'd20;
    localparam logic [5:0] LW_IDX    = 6'd21, LBU_IDX   = 6'd22, LHU_IDX   = 6'd23;
    localparam logic [5:0] SB_IDX    = 6'd24, SH_IDX    = 6'd25, SW_IDX    = 6'd26;
    localparam logic [5:0] BEQ_IDX   = 6'd27, BNE_IDX   = 6'd28, BLT_IDX   = 6'd29;
    localparam logic [5:0] BGE_IDX   = 6'd30, BLTU_IDX  = 6'd31, BGEU_IDX  = 6'd32;
    localparam logic [5:0] JAL_IDX   = 6'd33, JALR_IDX  = 6'd34, LUI_IDX   = 6'd35;
    localparam logic [5:0] AUIPC_IDX = 6'd36, ECALL_IDX = 6'd37, EBREAK_IDX = 6'd38;

    typedef logic [XLEN-1:0] result_t;

    typedef enum logic [1:0] {
        LS_BYTE = 2'd0,
        LS_HALF = 2'd1,
        LS_WORD = 2'd2
    } ls_size_e;

    function automatic result_t sext12(input logic [11:0] v);
        return {{(XLEN-12){v[11]}}, v};
    endfunction
endpackage

// File: rtl/alu_if.sv
// alu_if: data-memory bus between the ALU and the data memory.
//   addr          byte address (word index is addr[14:2])
//   rd_en, wr_en  read / full-word write enables
//   dmem_wr_data  word to write, dmem_rd_data combinational read word
// Modports: master (ALU side), slave (memory side).
interface alu_if;
    import alu_pkg::*;

    logic [DADDR_W-1:0] addr;
    logic               rd_en;
    logic               wr_en;
    result_t            dmem_wr_data;
    result_t            dmem_rd_data;

    modport master (output addr, rd_en, wr_en, dmem_wr_data, input dmem_rd_data);
    modport slave  (input addr, rd_en, wr_en, dmem_wr_data, output dmem_rd_data);
endinterface

// File: rtl/alu_lsu_lane.sv
// alu_lsu_lane: byte/half/word lane handling for loads and stores.
//   byte_off     address bits [1:0]
//   size         access size
//   is_unsigned  zero-extend loads (LBU/LHU) instead of sign-extending
//   rd_word      word read from memory
//   st_data      store source (rs2)
//   ld_data      extracted and extended load value
//   wr_word      rd_word with the addressed lane(s) replaced by st_data
module alu_lsu_lane
    import alu_pkg::*;
(
    input  logic [1:0] byte_off,
    input  ls_size_e   size,
    input  logic       is_unsigned,
    input  result_t    rd_word,
    input  result_t    st_data,
    output result_t    ld_data,
    output result_t    wr_word
);
    logic [7:0]  b_sel;
    logic [15:0] h_sel;

    always_comb begin
        b_sel = rd_word[8*byte_off +: 8];
        // Halfword lane uses addr[1] only; addr[0] is ignored (aligned down).
        h_sel = byte_off[1] ? rd_word[31:16] : rd_word[15:0];

        case (size)
            LS_BYTE: ld_data = is_unsigned ? {24'b0, b_sel} : {{24{b_sel[7]}}, b_sel};
            LS_HALF: ld_data = is_unsigned ? {16'b0, h_sel} : {{16{h_sel[15]}}, h_sel};
            default: ld_data = rd_word;
        endcase

        // Read-modify-write: memory only takes whole words.
        wr_word = rd_word;
        case (size)
            LS_BYTE: wr_word[8*byte_off +: 8]     = st_data[7:0];
            LS_HALF: wr_word[16*byte_off[1] +: 16] = st_data[15:0];
            default: wr_word = st_data;
        endcase
    end
endmodule

// File: rtl/alu.sv
// alu: RV32I execute-stage ALU with registered result and data-memory port.
//   clk, rst_n     clock, async active-low reset
//   rs1, rs2       operands (rs2 is also store data)
//   imm            12-bit immediate, sign-extended
//   PC             current instruction address
//   instructions   one-hot decoded instruction, highest set bit wins
//   ALUenabled     execute enable
//   dmem           data-memory bus (alu_if.master), combinational outputs
//   ALUoutput      registered result, 1-cycle latency
// Optional macro ALU_MISALIGN_EN: suppresses misaligned half/word accesses
// (no memory enables, result loads 0). Undefined: accesses align down.
module alu
    import alu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  result_t              rs1,
    input  result_t              rs2,
    input  logic [11:0]          imm,
    input  result_t              PC,
    input  logic [NUM_INSTR-1:0] instructions,
    input  logic                 ALUenabled,
    alu_if.master                dmem,
    output result_t              ALUoutput
);
    logic [5:0]         sel;
    logic               sel_vld;
    result_t            imm_x;
    logic [DADDR_W-1:0] eaddr;
    logic               is_load, is_store, misalign, mem_act, wr_en_i;
    ls_size_e           size;
    logic               uns;
    result_t            ld_data, wr_word, nxt;
    logic               upd;

    // Priority select: later (higher) set bits override earlier ones.
    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        for (int i = 0; i < NUM_INSTR; i++) begin
            if (instructions[i]) begin
                sel     = 6'(i);
                sel_vld = 1'b1;
            end
        end
    end

    assign imm_x    = sext12(imm);
    assign eaddr    = rs1[DADDR_W-1:0] + imm_x[DADDR_W-1:0];
    assign is_load  = sel_vld && (sel >= LB_IDX) && (sel <= LHU_IDX);
    assign is_store = sel_vld && (sel >= SB_IDX) && (sel <= SW_IDX);
    assign uns      = (sel == LBU_IDX) || (sel == LHU_IDX);

    always_comb begin
        case (sel)
            LB_IDX, LBU_IDX, SB_IDX: size = LS_BYTE;
            LH_IDX, LHU_IDX, SH_IDX: size = LS_HALF;
            default:                 size = LS_WORD;
        endcase
    end

`ifdef ALU_MISALIGN_EN
    assign misalign = (is_load || is_store) &&
                      (((size == LS_HALF) && eaddr[0]) ||
                       ((size == LS_WORD) && (eaddr[1:0] != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    alu_lsu_lane u_lane (
        .byte_off    (eaddr[1:0]),
        .size        (size),
        .is_unsigned (uns),
        .rd_word     (dmem.dmem_rd_data),
        .st_data     (rs2),
        .ld_data     (ld_data),
        .wr_word     (wr_word)
    );

    assign mem_act           = ALUenabled && (is_load || is_store);
    assign wr_en_i           = mem_act && is_store && !misalign;
    assign dmem.addr         = mem_act ? eaddr : '0;
    assign dmem.rd_en        = mem_act && !misalign;
    assign dmem.wr_en        = wr_en_i;
    assign dmem.dmem_wr_data = wr_en_i ? wr_word : '0;

    always_comb begin
        nxt = '0;
        upd = ALUenabled && sel_vld;
        case (sel)
            ADD_IDX:   nxt = rs1 + rs2;
            SUB_IDX:   nxt = rs1 - rs2;
            XOR_IDX:   nxt = rs1 ^ rs2;
            OR_IDX:    nxt = rs1 | rs2;
            AND_IDX:   nxt = rs1 & rs2;
            SLL_IDX:   nxt = rs1 << rs2[4:0];
            SRL_IDX:   nxt = rs1 >> rs2[4:0];
            SRA_IDX:   nxt = result_t'($signed(rs1) >>> rs2[4:0]);
            SLT_IDX:   nxt = {31'b0, $signed(rs1) < $signed(rs2)};
            SLTU_IDX:  nxt = {31'b0, rs1 < rs2};
            ADDI_IDX:  nxt = rs1 + imm_x;
            XORI_IDX:  nxt = rs1 ^ imm_x;
            ORI_IDX:   nxt = rs1 | imm_x;
            ANDI_IDX:  nxt = rs1 & imm_x;
            SLLI_IDX:  nxt = rs1 << imm[4:0];
            SRLI_IDX:  nxt = rs1 >> imm[4:0];
            SRAI_IDX:  nxt = result_t'($signed(rs1) >>> imm[4:0]);
            SLTI_IDX:  nxt = {31'b0, $signed(rs1) < $signed(imm_x)};
            SLTIU_IDX: nxt = {31'b0, rs1 < imm_x};
            LB_IDX, LH_IDX, LW_IDX, LBU_IDX, LHU_IDX:
                       nxt = misalign ? '0 : ld_data;
            // Aligned stores leave the result untouched; a suppressed one clears it.
            SB_IDX, SH_IDX, SW_IDX:
                       upd = ALUenabled && misalign;
            BEQ_IDX:   nxt = {31'b0, rs1 == rs2};
            BNE_IDX:   nxt = {31'b0, rs1 != rs2};
            BLT_IDX:   nxt = {31'b0, $signed(rs1) < $signed(rs2)};
            BGE_IDX:   nxt = {31'b0, $signed(rs1) >= $signed(rs2)};
            BLTU_IDX:  nxt = {31'b0, rs1 < rs2};
            BGEU_IDX:  nxt = {31'b0, rs1 >= rs2};
            JAL_IDX, JALR_IDX:
                       nxt = PC + 32'd4;
            LUI_IDX:   nxt = imm_x << 12;
            AUIPC_IDX: nxt = PC + (imm_x << 12);
            default:   nxt = '0;   // ECALL / EBREAK
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   ALUoutput <= '0;
        else if (upd) ALUoutput <= nxt;
    end
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed test-plan steps followed by randomized instructions
// checked against an arithmetic reference model.
module tb_alu;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] rs1, rs2, pc;
    logic [11:0] imm;
    logic [38:0] ins;
    logic        en;
    logic [31:0] alu_out;
    logic [31:0] exp_out;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    alu_if dmem ();

    alu dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rs1          (rs1),
        .rs2          (rs2),
        .imm          (imm),
        .PC           (pc),
        .instructions (ins),
        .ALUenabled   (en),
        .dmem         (dmem),
        .ALUoutput    (alu_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [38:0] bit1(input int idx);
        logic [38:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Reference model: picks the winning op and evaluates it with plain
    // integer arithmetic and masks.
    task automatic model(
        input  logic [38:0] i_ins, input logic i_en,
        input  logic [31:0] a, input logic [31:0] b, input logic [11:0] im,
        input  logic [31:0] p, input logic [31:0] rd,
        output logic upd, output logic [31:0] res,
        output logic [31:0] m_addr, output logic m_rd, output logic m_wr,
        output logic [31:0] m_wd);
        int          idx, sa, sb, simm, w, sh;
        logic [31:0] ui, ea, off, bv, hv, mask;
        logic        bad;
        idx = -1;
        for (int k = 38; k >= 0; k--) if (i_ins[k] && idx < 0) idx = k;
        sa = a; sb = b;
        simm = int'($signed(im));
        ui = simm;
        ea = a + ui;
        off = ea % 4;
        bv = (rd >> (8 * off)) & 32'hFF;
        hv = (rd >> (16 * (off / 2))) & 32'hFFFF;
        w  = (idx == 24) ? 8 : (idx == 25) ? 16 : 32;
        sh = (w == 8) ? 8 * off : (w == 16) ? 16 * (off / 2) : 0;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 1);
        bad = 1'b0;
`ifdef ALU_MISALIGN_EN
        if ((idx == 20 || idx == 23 || idx == 25) && (off % 2 != 0)) bad = 1'b1;
        if ((idx == 21 || idx == 26) && off != 0) bad = 1'b1;
`endif
        upd = i_en && idx >= 0;
        res = 0;
        case (idx)
            0:  res = a + b;
            1:  res = a - b;
            2:  res = a ^ b;
            3:  res = a | b;
            4:  res = a & b;
            5:  res = a << (b % 32);
            6:  res = a >> (b % 32);
            7:  res = sa >>> (b % 32);
            8:  res = (sa < sb) ? 1 : 0;
            9:  res = (a < b) ? 1 : 0;
            10: res = a + ui;
            11: res = a ^ ui;
            12: res = a | ui;
            13: res = a & ui;
            14: res = a << (im % 32);
            15: res = a >> (im % 32);
            16: res = sa >>> (im % 32);
            17: res = (sa < simm) ? 1 : 0;
            18: res = (a < ui) ? 1 : 0;
            19: res = (bv >= 128) ? bv - 256 : bv;
            20: res = (hv >= 32768) ? hv - 65536 : hv;
            21: res = rd;
            22: res = bv;
            23: res = hv;
            24, 25, 26: upd = i_en && bad;
            27: res = (a == b) ? 1 : 0;
            28: res = (a != b) ? 1 : 0;
            29: res = (sa < sb) ? 1 : 0;
            30: res = (sa >= sb) ? 1 : 0;
            31: res = (a < b) ? 1 : 0;
            32: res = (a >= b) ? 1 : 0;
            33, 34: res = p + 4;
            35: res = ui * 4096;
            36: res = p + ui * 4096;
            default: res = 0;
        endcase
        if (bad) res = 0;
        m_addr = 0; m_rd = 0; m_wr = 0; m_wd = 0;
        if (i_en && idx >= 19 && idx <= 26) begin
            m_addr = ea % 32768;
            m_rd   = !bad;
            if (idx >= 24 && !bad) begin
                m_wr = 1'b1;
                m_wd = (rd & ~(mask << sh)) | ((b & mask) << sh);
            end
        end
    endtask

    initial begin
        logic        m_upd, m_rd, m_wr;
        logic [31:0] m_res, m_addr, m_wd;

        rst_n = 1'b0; en = 1'b0; ins = '0;
        rs1 = '0; rs2 = '0; imm = '0; pc = '0;
        dmem.dmem_rd_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out", alu_out, 32'h0);
        check("reset_rd_en", 32'(dmem.rd_en), 32'h0);
        rst_n = 1'b1;

        // Cumulative bits, highest set bit wins
        rs1 = 32'd5; rs2 = 32'd4; imm = 12'd12; pc = 32'd2; en = 1'b1;
        ins[0] = 1'b1;  tick(); check("add", alu_out, 32'd9);
        ins[1] = 1'b1;  tick(); check("sub", alu_out, 32'd1);
        ins[7] = 1'b1;  tick(); check("sra", alu_out, 32'd0);
        ins[18] = 1'b1; tick(); check("sltiu", alu_out, 32'd1);
        ins[33] = 1'b1; tick(); check("jal", alu_out, 32'd6);
        ins[35] = 1'b1; tick(); check("lui", alu_out, 32'h0000C000);
        ins[36] = 1'b1; tick(); check("auipc", alu_out, 32'h0000C002);

        // Asynchronous reset, away from any clock edge
        #2 rst_n = 1'b0;
        #1 check("async_reset", alu_out, 32'h0);
        #3 rst_n = 1'b1;
        ins = bit1(0); tick(); check("add_after_rst", alu_out, 32'd9);

        // Disabled: output holds, memory idle
        en = 1'b0; ins = bit1(0) | bit1(21); rs1 = 32'h100; imm = 12'd4;
        #1;
        check("dis_rd_en", 32'(dmem.rd_en), 32'h0);
        check("dis_addr", 32'(dmem.addr), 32'h0);
        tick(); check("dis_hold", alu_out, 32'd9);

        // Loads
        en = 1'b1; ins = bit1(21); dmem.dmem_rd_data = 32'hDEADBEEF;
        #1;
        check("lw_addr", 32'(dmem.addr), 32'h104);
        check("lw_rd_en", 32'(dmem.rd_en), 32'h1);
        check("lw_wr_en", 32'(dmem.wr_en), 32'h0);
        tick(); check("lw", alu_out, 32'hDEADBEEF);
        ins = bit1(19); imm = 12'd3; tick(); check("lb", alu_out, 32'hFFFFFFDE);
        ins = bit1(22); tick(); check("lbu", alu_out, 32'h000000DE);

        // Stores (read-modify-write)
        ins = bit1(24); rs1 = 32'h101; imm = 12'd0; rs2 = 32'hAB;
        dmem.dmem_rd_data = 32'h11223344;
        #1;
        check("sb_wr_en", 32'(dmem.wr_en), 32'h1);
        check("sb_rd_en", 32'(dmem.rd_en), 32'h1);
        check("sb_data", dmem.dmem_wr_data, 32'h1122AB44);
        tick(); check("sb_hold", alu_out, 32'h000000DE);
        ins = bit1(25); rs1 = 32'h102; rs2 = 32'hBEEF;
        #1 check("sh_data", dmem.dmem_wr_data, 32'hBEEF3344);
        tick();

        // Branches
        rs1 = 32'hFFFFFFFF; rs2 = 32'd1;
        ins = bit1(29); tick(); check("blt", alu_out, 32'd1);
        ins = bit1(31); tick(); check("bltu", alu_out, 32'd0);
        ins = bit1(28); tick(); check("bne", alu_out, 32'd1);
        ins = bit1(27); tick(); check("beq", alu_out, 32'd0);

        // Misaligned word load
        ins = bit1(21); rs1 = 32'h102; imm = 12'd0; dmem.dmem_rd_data = 32'hCAFEF00D;
        #1;
`ifdef ALU_MISALIGN_EN
        check("lw_mis_rd_en", 32'(dmem.rd_en), 32'h0);
        tick(); check("lw_mis", alu_out, 32'h0);
        exp_out = 32'h0;
`else
        check("lw_mis_rd_en", 32'(dmem.rd_en), 32'h1);
        tick(); check("lw_mis", alu_out, 32'hCAFEF00D);
        exp_out = 32'hCAFEF00D;
`endif

        // Randomized instructions against the reference model
        for (int n = 0; n < 300; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0)      ins = '0;
            else if (r < 3)  ins = bit1(int'($urandom_range(0, 38))) | bit1(int'($urandom_range(0, 38)));
            else             ins = bit1(int'($urandom_range(0, 38)));
            en  = ($urandom_range(0, 7) != 0);
            rs1 = $urandom; rs2 = $urandom; pc = $urandom;
            imm = 12'($urandom);
            dmem.dmem_rd_data = $urandom;
            #1;
            model(ins, en, rs1, rs2, imm, pc, dmem.dmem_rd_data,
                  m_upd, m_res, m_addr, m_rd, m_wr, m_wd);
            check("rnd_addr", 32'(dmem.addr), m_addr);
            check("rnd_rd_en", 32'(dmem.rd_en), 32'(m_rd));
            check("rnd_wr_en", 32'(dmem.wr_en), 32'(m_wr));
            check("rnd_wr_data", dmem.dmem_wr_data, m_wd);
            tick();
            if (m_upd) exp_out = m_res;
            check("rnd_out", alu_out, exp_out);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
